// File: rtl/lsu_sequencer.sv
// lsu_sequencer: MIPS byte/half/word loads and stores over a 16-bit big-endian memory port; `define MISALIGN_TRAP_EN traps misaligned accesses
module lsu_sequencer #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 uns,
  input  logic                 dirty,
  input  logic                 skip,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic                 misalign,
  output logic                 mem_wr,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_di,
  input  logic [DATAWIDTH-1:0] mem_do
);
  typedef enum logic [1:0] {IDLE, WORD2, RMW_WR} state_t;
  state_t state, next;
  logic [DATAWIDTH-1:0] hi_q;
  logic kill_q, kill, mis;
  logic [7:0] bsel;
  logic [ADDRWIDTH-1:0] half_addr, word_addr;
  assign kill = dirty | skip;
  assign bsel = addr[0] ? mem_do[7:0] : mem_do[15:8];
  assign half_addr = {addr[ADDRWIDTH-1:1], 1'b0};
  assign word_addr = {addr[ADDRWIDTH-1:2], 2'b00};
`ifdef MISALIGN_TRAP_EN
  assign mis = req && ((size == 2'b10 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]));
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    next = state;
    rdata = '0;
    stall = 1'b0;
    misalign = 1'b0;
    mem_wr = 1'b0;
    mem_addr = '0;
    mem_di = '0;
    case (state)
      IDLE: begin
        if (mis) misalign = 1'b1;
        else if (req) begin
          case (size)
            2'b00: begin
              mem_addr = half_addr;
              stall = we;
              next = we ? RMW_WR : IDLE;
              rdata = uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            end
            2'b01: begin
              mem_addr = half_addr;
              mem_wr = we & !kill;
              mem_di = wdata[15:0];
              rdata = uns ? {16'b0, mem_do} : {{16{mem_do[15]}}, mem_do};
            end
            2'b10: begin
              mem_addr = word_addr;
              mem_wr = we & !kill;
              mem_di = wdata[31:16];
              stall = 1'b1;
              next = WORD2;
            end
            default: ;
          endcase
        end
      end
      WORD2: begin
        mem_addr = {addr[ADDRWIDTH-1:2], 2'b10};
        mem_wr = we & !kill_q;
        mem_di = wdata[15:0];
        rdata = {hi_q, mem_do};
        next = IDLE;
      end
      RMW_WR: begin
        mem_addr = half_addr;
        mem_wr = !kill_q;
        mem_di = addr[0] ? {hi_q[15:8], wdata[7:0]} : {wdata[7:0], hi_q[7:0]};
        next = IDLE;
      end
      default: next = IDLE;
    endcase
    if (!rst_n) begin
      next = IDLE;
      rdata = '0;
      stall = 1'b0;
      misalign = 1'b0;
      mem_wr = 1'b0;
      mem_addr = '0;
      mem_di = '0;
    end
  end
  // first cycle of a multi-cycle op captures the read half and the kill decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi_q <= '0;
      kill_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && next != IDLE) begin
        hi_q <= mem_do;
        kill_q <= kill;
      end
    end
  end
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed vectors; per-cycle expectations queued by stimulus, checked by a negedge monitor
module tb_lsu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0, dirty = 1'b0, skip = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, rdata, mem_addr;
  logic stall, misalign, mem_wr;
  logic [15:0] mem_di, mem_do;
  logic [15:0] mem [0:1023];
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;
  typedef struct {
    string nm;
    logic st, wr, mis, ca, cd, cr;
    logic [31:0] a;
    logic [15:0] di;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];
  int n = 0, bad = 0;

  lsu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .dirty(dirty), .skip(skip), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;
  assign mem_do = mem[mem_addr[10:1]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[10:1]] <= mem_di;

  function automatic exp_t ex(string nm, logic st, logic wr, logic ca, logic [31:0] a,
                              logic cd, logic [15:0] di, logic cr, logic [31:0] rd, logic mis = 1'b0);
    exp_t e;
    e.nm = nm; e.st = st; e.wr = wr; e.ca = ca; e.a = a;
    e.cd = cd; e.di = di; e.cr = cr; e.rd = rd; e.mis = mis;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req_v);
    n++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req_v);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk({x.nm, " stall"}, {31'b0, stall}, {31'b0, x.st});
      chk({x.nm, " mem_wr"}, {31'b0, mem_wr}, {31'b0, x.wr});
      chk({x.nm, " misalign"}, {31'b0, misalign}, {31'b0, x.mis});
      if (x.ca) chk({x.nm, " mem_addr"}, mem_addr, x.a);
      if (x.cd) chk({x.nm, " mem_di"}, {16'b0, mem_di}, {16'b0, x.di});
      if (x.cr) chk({x.nm, " rdata"}, rdata, x.rd);
    end
  end

  task automatic step(input logic r, input logic w, input logic [1:0] s, input logic u,
                      input logic d, input logic k, input logic [31:0] a, input logic [31:0] wd,
                      input exp_t e);
    req = r; we = w; size = s; uns = u; dirty = d; skip = k; addr = a; wdata = wd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[10'h100] = 16'h1234;
    mem[10'h101] = 16'h8001;
    @(posedge clk);
    #1;
    step(1, 1, W, 0, 0, 0, 32'h100, 32'hDEADBEEF, ex("reset", 0, 0, 1, 0, 1, 0, 1, 0));
    rst_n = 1'b1;
    step(0, 0, B, 0, 0, 0, 32'h100, 0, ex("idle", 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, W, 0, 0, 0, 32'h100, 32'hDEADBEEF, ex("sw c1", 1, 1, 1, 32'h100, 1, 16'hDEAD, 0, 0));
    step(1, 1, W, 0, 0, 0, 32'h100, 32'hDEADBEEF, ex("sw c2", 0, 1, 1, 32'h102, 1, 16'hBEEF, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h100, 0, ex("lw c1", 1, 0, 1, 32'h100, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h100, 0, ex("lw c2", 0, 0, 1, 32'h102, 0, 0, 1, 32'hDEADBEEF));
    step(1, 1, B, 0, 0, 0, 32'h201, 32'h123456AB, ex("sb c1", 1, 0, 1, 32'h200, 0, 0, 0, 0));
    step(1, 1, B, 0, 0, 0, 32'h201, 32'h123456AB, ex("sb c2", 0, 1, 1, 32'h200, 1, 16'h12AB, 0, 0));
    step(1, 0, B, 1, 0, 0, 32'h201, 0, ex("lbu 201", 0, 0, 1, 32'h200, 0, 0, 1, 32'h000000AB));
    step(1, 0, B, 0, 0, 0, 32'h201, 0, ex("lb 201", 0, 0, 1, 32'h200, 0, 0, 1, 32'hFFFFFFAB));
    step(1, 0, B, 0, 0, 0, 32'h200, 0, ex("lb 200", 0, 0, 1, 32'h200, 0, 0, 1, 32'h00000012));
    step(1, 0, H, 0, 0, 0, 32'h202, 0, ex("lh 202", 0, 0, 1, 32'h202, 0, 0, 1, 32'hFFFF8001));
    step(1, 0, H, 1, 0, 0, 32'h202, 0, ex("lhu 202", 0, 0, 1, 32'h202, 0, 0, 1, 32'h00008001));
    step(1, 1, B, 0, 0, 0, 32'h200, 32'h0000007F, ex("sb0 c1", 1, 0, 1, 32'h200, 0, 0, 0, 0));
    step(1, 1, B, 0, 0, 0, 32'h200, 32'h0000007F, ex("sb0 c2", 0, 1, 1, 32'h200, 1, 16'h7FAB, 0, 0));
    step(1, 0, H, 1, 0, 0, 32'h200, 0, ex("lhu 200", 0, 0, 1, 32'h200, 0, 0, 1, 32'h00007FAB));
    step(1, 1, H, 0, 0, 0, 32'h300, 32'hFFFF5A5A, ex("sh 300", 0, 1, 1, 32'h300, 1, 16'h5A5A, 0, 0));
    step(1, 0, H, 0, 0, 0, 32'h300, 0, ex("lh 300", 0, 0, 1, 32'h300, 0, 0, 1, 32'h00005A5A));
    step(1, 1, W, 0, 0, 1, 32'h100, 32'h11112222, ex("sw skip c1", 1, 0, 1, 32'h100, 0, 0, 0, 0));
    step(1, 1, W, 0, 0, 0, 32'h100, 32'h11112222, ex("sw skip c2", 0, 0, 1, 32'h102, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h100, 0, ex("lw2 c1", 1, 0, 1, 32'h100, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h100, 0, ex("lw2 c2", 0, 0, 1, 32'h102, 0, 0, 1, 32'hDEADBEEF));
    step(1, 1, B, 0, 1, 0, 32'h200, 32'h55, ex("sb dirty c1", 1, 0, 1, 32'h200, 0, 0, 0, 0));
    step(1, 1, B, 0, 0, 0, 32'h200, 32'h55, ex("sb dirty c2", 0, 0, 1, 32'h200, 0, 0, 0, 0));
    step(1, 0, H, 1, 0, 0, 32'h200, 0, ex("lhu 200b", 0, 0, 1, 32'h200, 0, 0, 1, 32'h00007FAB));
    step(1, 1, X, 0, 0, 0, 32'h300, 32'h0, ex("nop", 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, H, 1, 0, 0, 32'h300, 0, ex("lhu 300", 0, 0, 1, 32'h300, 0, 0, 1, 32'h00005A5A));
    step(1, 1, W, 0, 0, 0, 32'hFFFFFFFC, 32'hCAFEF00D, ex("sw wrap c1", 1, 1, 1, 32'hFFFFFFFC, 1, 16'hCAFE, 0, 0));
    step(1, 1, W, 0, 0, 0, 32'hFFFFFFFC, 32'hCAFEF00D, ex("sw wrap c2", 0, 1, 1, 32'hFFFFFFFE, 1, 16'hF00D, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'hFFFFFFFC, 0, ex("lw wrap c1", 1, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'hFFFFFFFC, 0, ex("lw wrap c2", 0, 0, 1, 32'hFFFFFFFE, 0, 0, 1, 32'hCAFEF00D));
`ifdef MISALIGN_TRAP_EN
    step(1, 1, W, 0, 0, 0, 32'h102, 32'h99998888, ex("mis sw", 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(1, 0, H, 0, 0, 0, 32'h203, 0, ex("mis lh", 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(1, 0, W, 0, 0, 0, 32'h100, 0, ex("lw3 c1", 1, 0, 1, 32'h100, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h100, 0, ex("lw3 c2", 0, 0, 1, 32'h102, 0, 0, 1, 32'hDEADBEEF));
`else
    step(1, 0, W, 0, 0, 0, 32'h103, 0, ex("lw mis c1", 1, 0, 1, 32'h100, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h103, 0, ex("lw mis c2", 0, 0, 1, 32'h102, 0, 0, 1, 32'hDEADBEEF));
    step(1, 1, H, 0, 0, 0, 32'h301, 32'h0000C3C3, ex("sh mis", 0, 1, 1, 32'h300, 1, 16'hC3C3, 0, 0));
    step(1, 0, H, 1, 0, 0, 32'h300, 0, ex("lhu 300b", 0, 0, 1, 32'h300, 0, 0, 1, 32'h0000C3C3));
`endif
    step(1, 1, W, 0, 0, 0, 32'h400, 32'hAAAA5555, ex("sw rst c1", 1, 1, 1, 32'h400, 1, 16'hAAAA, 0, 0));
    rst_n = 1'b0;
    step(1, 1, W, 0, 0, 0, 32'h400, 32'hAAAA5555, ex("sw rst c2", 0, 0, 1, 0, 1, 0, 1, 0));
    rst_n = 1'b1;
    step(0, 0, B, 0, 0, 0, 32'h400, 0, ex("after rst", 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h400, 0, ex("lw 400 c1", 1, 0, 1, 32'h400, 0, 0, 0, 0));
    step(1, 0, W, 0, 0, 0, 32'h400, 0, ex("lw 400 c2", 0, 0, 1, 32'h402, 0, 0, 1, 32'hAAAA0000));
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
